usb_reg_responder: RTL
======================

# usb_reg_responder

Target-side responder for the parallel USB register bus driven by the SAM3U/host: USB_Addr, USB_Data, USB_RDn, USB_WRn, USB_CEn, USB_ALEn. It samples the bus on clk_usb and latches the register address during the address phase. Each data strobe becomes one single-cycle reg_read or reg_write pulse, indexed by an auto-incrementing byte counter. It sits between the top-level bus pins and the register blocks (sad, trigger, capture control), which decode reg_address/reg_bytecnt.

## Interface
- pBYTECNT_SIZE, 7: width of reg_bytecnt; counter wraps modulo 2^pBYTECNT_SIZE.
- pADDR_WIDTH, 8: width of USB_Addr and reg_address.
- clk_usb  in  1  bus/register clock; all bus inputs are synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- USB_Addr  in  pADDR_WIDTH  register address, valid during address phase.
- usb_din  in  8  USB_Data input half (top level owns the tristate).
- usb_dout  out  8  read data to USB_Data.
- usb_isout  out  1  USB_Data output enable.
- USB_RDn, USB_WRn, USB_CEn, USB_ALEn  in  1 each  active-low bus strobes.
- reg_address  out  pADDR_WIDTH  latched register address.
- reg_bytecnt  out  pBYTECNT_SIZE  byte index within current address.
- reg_addrvalid  out  1  high from first address phase until reset.
- reg_datao  out  8  write data to register blocks.
- reg_datai  in  8  read data from register blocks; combinational function of reg_address/reg_bytecnt.
- reg_write  out  1  one-cycle write strobe.
- reg_read  out  1  one-cycle read strobe.

## Operation
- Sampler: all bus inputs are registered once per clk_usb. The FSM sees only the sampled copies (s_*) and their previous values (p_*).
- FSM states:
  - IDLE.
  - ADDR: s_CEn=0 & s_ALEn=0. Latch reg_address←s_Addr, reg_bytecnt←0, reg_addrvalid←1 every cycle. Return to IDLE when ALEn rises.
  - WR_STROBE: from IDLE on s_WRn falling (p_WRn=1, s_WRn=0) with s_CEn=0, s_ALEn=1.
    - reg_write=1 for exactly this cycle; reg_datao←s_din.
    - Always goes to WR_HOLD.
  - WR_HOLD: wait until s_WRn=1. Then reg_bytecnt+1 and go to IDLE.
  - RD_STROBE: from IDLE on s_RDn falling with s_CEn=0, s_ALEn=1.
    - reg_read=1 for this cycle.
    - Capture reg_datai into usb_dout at end of cycle.
  - RD_HOLD: usb_isout=1.
    - Exit when s_RDn=1: usb_isout→0, reg_bytecnt+1, go to IDLE.
- Simultaneous WRn and RDn falling: write wins; the read is ignored, with no reg_read.
- s_CEn rising in WR_HOLD/RD_HOLD: abort to IDLE with no bytecnt increment; usb_isout→0 next cycle.
- An ALEn-low sample while in a HOLD state is ignored until IDLE.
- Byte counter: unsigned modulo 2^pBYTECNT_SIZE; 2^pBYTECNT_SIZE-1 wraps to 0.
- usb_dout holds its last captured value outside RD_HOLD. usb_isout is the only qualifier.

## Timing
- Reset values: usb_dout=0, usb_isout=0, reg_address=0, reg_bytecnt=0, reg_addrvalid=0, reg_datao=0, reg_write=0, reg_read=0, state IDLE. Reset is asynchronous and also applies mid-transaction.
- Edge k = first clk_usb edge sampling WRn/RDn low. The strobe is high in the cycle following edge k+1, i.e. 2 cycles of latency.
- reg_datai must be valid during the RD_STROBE cycle. usb_dout/usb_isout are valid from edge k+2.
- The host must sample read data ≥3 clk_usb cycles after RDn falls.
- Strobes must stay low ≥3 cycles and high ≥2 cycles. Shorter pulses are unsupported.
- reg_bytecnt changes 1 cycle after the HOLD exit is detected (edge where s_RDn/s_WRn=1).

## Structure
- Shared package usb_reg_pkg:
  - FSM state enum (IDLE, ADDR, WR_STROBE, WR_HOLD, RD_STROBE, RD_HOLD).
  - Default widths for pBYTECNT_SIZE/pADDR_WIDTH.
- One sub-module, usb_bus_sampler: input register stage plus p_* history and falling/rising-edge flags.

## Test plan
- Address phase 0x2A, then writes 0x11,0x22,0x33,0x44 → four reg_write pulses with bytecnt 0,1,2,3 and matching reg_datao; reg_bytecnt=4, reg_address=0x2A after.
- Address 0x05, fabric reg_datai=0xA0+bytecnt, three reads → usb_dout 0xA0,0xA1,0xA2; usb_isout high only in RD_HOLD; reg_read exactly 3 pulses.
- pBYTECNT_SIZE=7, 130 consecutive writes → reg_bytecnt sequence 0..127,0,1; final value 2.
- WRn low 5 cycles, CEn raised before WRn rises → one reg_write, bytecnt unchanged; next write uses the same bytecnt.
- reset_n asserted during RD_HOLD → usb_isout=0 and all outputs at reset values without waiting for a clock edge; next address phase works normally.
- WRn and RDn both fall on the same sample → one reg_write, zero reg_read, usb_isout stays 0, bytecnt +1.

Source files
------------

// File: rtl/usb_reg_pkg.sv
// Shared types and default widths for the USB register bus responder.
package usb_reg_pkg;

  localparam int BYTECNT_SIZE_DEF = 7;
  localparam int ADDR_WIDTH_DEF   = 8;

  // Responder FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_WR_STROBE = 3'd2,
    ST_WR_HOLD   = 3'd3,
    ST_RD_STROBE = 3'd4,
    ST_RD_HOLD   = 3'd5
  } reg_state_e;

endpackage

// File: rtl/usb_reg_responder_if.sv
// Parallel USB register bus as seen at the FPGA pins (data tristate split
// into din/dout/isout; the top level owns the pad).
interface usb_reg_responder_if #(
  parameter int pADDR_WIDTH = 8
);
  logic [pADDR_WIDTH-1:0] USB_Addr;
  logic [7:0]             usb_din;
  logic [7:0]             usb_dout;
  logic                   usb_isout;
  logic                   USB_RDn;
  logic                   USB_WRn;
  logic                   USB_CEn;
  logic                   USB_ALEn;

  // Host side drives address, data and strobes
  modport master (
    output USB_Addr, usb_din, USB_RDn, USB_WRn, USB_CEn, USB_ALEn,
    input  usb_dout, usb_isout
  );

  // Responder side returns read data and the output enable
  modport slave (
    input  USB_Addr, usb_din, USB_RDn, USB_WRn, USB_CEn, USB_ALEn,
    output usb_dout, usb_isout
  );
endinterface

// File: rtl/usb_bus_sampler.sv
// Single register stage on every bus input plus one cycle of strobe
// history, producing falling-edge flags for the data strobes.
module usb_bus_sampler #(
  parameter int pADDR_WIDTH = 8
) (
  input  logic                   clk_usb,
  input  logic                   reset_n,
  input  logic [pADDR_WIDTH-1:0] addr,
  input  logic [7:0]             din,
  input  logic                   rdn,
  input  logic                   wrn,
  input  logic                   cen,
  input  logic                   alen,
  output logic [pADDR_WIDTH-1:0] s_addr,
  output logic [7:0]             s_din,
  output logic                   s_rdn,
  output logic                   s_wrn,
  output logic                   s_cen,
  output logic                   s_alen,
  output logic                   wr_fall,
  output logic                   rd_fall
);

  logic p_rdn;
  logic p_wrn;

  // Sample the bus; strobes reset to their inactive (high) level so that
  // releasing reset can never look like a falling edge.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      s_addr <= '0;
      s_din  <= '0;
      s_rdn  <= 1'b1;
      s_wrn  <= 1'b1;
      s_cen  <= 1'b1;
      s_alen <= 1'b1;
      p_rdn  <= 1'b1;
      p_wrn  <= 1'b1;
    end else begin
      s_addr <= addr;
      s_din  <= din;
      s_rdn  <= rdn;
      s_wrn  <= wrn;
      s_cen  <= cen;
      s_alen <= alen;
      p_rdn  <= s_rdn;
      p_wrn  <= s_wrn;
    end
  end

  assign wr_fall = p_wrn & ~s_wrn;
  assign rd_fall = p_rdn & ~s_rdn;

endmodule

// File: rtl/usb_reg_responder.sv
// Target-side responder for the SAM3U parallel register bus. Latches the
// register address during ALE, turns each data strobe into a one-cycle
// reg_read/reg_write pulse and auto-increments the byte index.
module usb_reg_responder
  import usb_reg_pkg::*;
#(
  parameter int pBYTECNT_SIZE = BYTECNT_SIZE_DEF,
  parameter int pADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic                     clk_usb,
  input  logic                     reset_n,
  usb_reg_responder_if.slave       bus,
  output logic [pADDR_WIDTH-1:0]   reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic                     reg_addrvalid,
  output logic [7:0]               reg_datao,
  input  logic [7:0]               reg_datai,
  output logic                     reg_write,
  output logic                     reg_read
);

  logic [pADDR_WIDTH-1:0] s_addr;
  logic [7:0]             s_din;
  logic                   s_rdn;
  logic                   s_wrn;
  logic                   s_cen;
  logic                   s_alen;
  logic                   wr_fall;
  logic                   rd_fall;

  reg_state_e state;
  logic [7:0] dout_q;
  logic       isout_q;

  usb_bus_sampler #(
    .pADDR_WIDTH (pADDR_WIDTH)
  ) u_sampler (
    .clk_usb (clk_usb),
    .reset_n (reset_n),
    .addr    (bus.USB_Addr),
    .din     (bus.usb_din),
    .rdn     (bus.USB_RDn),
    .wrn     (bus.USB_WRn),
    .cen     (bus.USB_CEn),
    .alen    (bus.USB_ALEn),
    .s_addr  (s_addr),
    .s_din   (s_din),
    .s_rdn   (s_rdn),
    .s_wrn   (s_wrn),
    .s_cen   (s_cen),
    .s_alen  (s_alen),
    .wr_fall (wr_fall),
    .rd_fall (rd_fall)
  );

  assign bus.usb_dout  = dout_q;
  assign bus.usb_isout = isout_q;

  // Bus FSM: address latch, strobe generation, hold/abort and byte counter.
  // Write is checked before read in IDLE so a simultaneous fall drops the read.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      reg_addrvalid <= 1'b0;
      reg_datao     <= '0;
      reg_write     <= 1'b0;
      reg_read      <= 1'b0;
      dout_q        <= '0;
      isout_q       <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      reg_read  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!s_cen && !s_alen) begin
            state         <= ST_ADDR;
            reg_address   <= s_addr;
            reg_bytecnt   <= '0;
            reg_addrvalid <= 1'b1;
          end else if (!s_cen && s_alen && wr_fall) begin
            state     <= ST_WR_STROBE;
            reg_write <= 1'b1;
            reg_datao <= s_din;
          end else if (!s_cen && s_alen && rd_fall) begin
            state    <= ST_RD_STROBE;
            reg_read <= 1'b1;
          end
        end
        ST_ADDR: begin
          // Keep tracking the address while ALE is held; leave once it is
          // released (or the chip is deselected).
          if (s_alen || s_cen) begin
            state <= ST_IDLE;
          end else begin
            reg_address   <= s_addr;
            reg_bytecnt   <= '0;
            reg_addrvalid <= 1'b1;
          end
        end
        ST_WR_STROBE: begin
          state <= ST_WR_HOLD;
        end
        ST_WR_HOLD: begin
          // Deselect mid-strobe aborts without consuming a byte index
          if (s_cen) begin
            state <= ST_IDLE;
          end else if (s_wrn) begin
            state       <= ST_IDLE;
            reg_bytecnt <= reg_bytecnt + 1'b1;
          end
        end
        ST_RD_STROBE: begin
          // reg_datai is valid this cycle; hold it on the pins for the host
          state   <= ST_RD_HOLD;
          dout_q  <= reg_datai;
          isout_q <= 1'b1;
        end
        ST_RD_HOLD: begin
          if (s_cen) begin
            state   <= ST_IDLE;
            isout_q <= 1'b0;
          end else if (s_rdn) begin
            state       <= ST_IDLE;
            isout_q     <= 1'b0;
            reg_bytecnt <= reg_bytecnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
